divider: RTL and testbench

Iterative radix-2 restoring divider for the EX stage, producing 32-bit quotient and remainder in signed or unsigned mode. It complements the combinational Wallace-tree `multiplier` for the DIV/MOD instruction group. Operands are accepted over a valid/ready handshake, and results are held until the pipeline consumes them. A flush input aborts an in-flight operation.

---
 rtl/divider_pkg.sv | 11 +
 rtl/div_step.sv | 20 ++
 rtl/divider.sv | 104 ++++++++++
 tb/tb_divider.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared constants and state encoding for the iterative restoring divider.
package divider_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;
endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring step: shift in a dividend bit, trial-subtract.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   prem,
  input  logic             dbit,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH:0]   prem_nxt,
  output logic             qbit
);
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  assign shifted = {prem[WIDTH-1:0], dbit};
  assign diff    = {1'b0, shifted} - {2'b00, dsr};
  // A set prem MSB means the true shifted value exceeds any divisor, so the
  // subtract must succeed; the low bits of diff stay correct under wrap.
  assign qbit     = prem[WIDTH] | ~diff[WIDTH+1];
  assign prem_nxt = qbit ? diff[WIDTH:0] : shifted;
endmodule

// File: rtl/divider.sv
// Iterative signed/unsigned divider: valid/ready operands in, held result out, cancel flush.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  input  logic             cancel
);
  localparam int CW = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_q, dsr_q, raw_q;
  logic [WIDTH:0]   prem_q;
  logic             q_neg_q, r_neg_q, dz_q;

  logic             accept, last_step, step_qbit;
  logic [WIDTH:0]   step_prem;
  logic [WIDTH-1:0] dvd_abs, dsr_abs, q_mag, r_mag, q_fix, r_fix;

  assign accept    = in_valid && in_ready && !cancel;
  assign last_step = (state_q == DIV_CALC) && (cnt_q == CW'(WIDTH-1));

  assign dvd_abs = (div_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dsr_abs = (div_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .prem     (prem_q),
    .dbit     (dvd_q[WIDTH-1]),
    .dsr      (dsr_q),
    .prem_nxt (step_prem),
    .qbit     (step_qbit)
  );

  // Quotient bits shift into the vacated low end of the dividend register.
  assign q_mag = {dvd_q[WIDTH-2:0], step_qbit};
  assign r_mag = step_prem[WIDTH-1:0];
  assign q_fix = dz_q ? '1    : (q_neg_q ? -q_mag : q_mag);
  assign r_fix = dz_q ? raw_q : (r_neg_q ? -r_mag : r_mag);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= DIV_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE: if (accept)    state_d = DIV_CALC;
      DIV_CALC: if (last_step) state_d = DIV_DONE;
      DIV_DONE: if (out_ready) state_d = DIV_IDLE;
      default:                 state_d = DIV_IDLE;
    endcase
    if (cancel) state_d = DIV_IDLE;
  end

  always_comb begin
    in_ready  = (state_q == DIV_IDLE);
    out_valid = (state_q == DIV_DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      raw_q     <= '0;
      prem_q    <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dz_q      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (accept) begin
      cnt_q   <= '0;
      dvd_q   <= dvd_abs;
      dsr_q   <= dsr_abs;
      raw_q   <= dividend;
      prem_q  <= '0;
      q_neg_q <= div_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      r_neg_q <= div_signed && dividend[WIDTH-1];
      dz_q    <= (divisor == '0);
    end else if (state_q == DIV_CALC && !cancel) begin
      cnt_q  <= cnt_q + 1'b1;
      dvd_q  <= q_mag;
      prem_q <= step_prem;
      if (last_step) begin
        quotient  <= q_fix;
        remainder <= r_fix;
      end
    end
  end
endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed table, handshake/cancel/reset corners, random vs model.
module tb_divider;
  logic        clk = 1'b0, resetn = 1'b0;
  logic        in_valid = 1'b0, div_signed = 1'b0, out_ready = 1'b0, cancel = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic        in_ready, out_valid;
  logic [31:0] quotient, remainder;

  int passed = 0, total = 0;

  divider dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .div_signed(div_signed), .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
    .remainder(remainder), .cancel(cancel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a, b, q, r;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division semantics plus the zero/overflow rules.
  task automatic model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!sgn) begin
      q = a / b; r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 0;
    end else begin
      sa = a; sb = b;
      q = sa / sb; r = sa % sb;
    end
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    while (!out_valid && n < 64) begin
      tick;
      n++;
    end
    chk({tag, "_latency"}, n, 32);
  endtask

  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input string tag);
    in_valid = 1'b1; div_signed = sgn; dividend = a; divisor = b;
    tick;
    in_valid = 1'b0; dividend = $urandom; divisor = $urandom; div_signed = $urandom_range(0, 1);
    wait_result(tag);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    tbl[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    tbl[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    tbl[4] = '{1'b0, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  32'hF};
    tbl[5] = '{1'b0, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234};
    tbl[6] = '{1'b1, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234};
    tbl[7] = '{1'b0, 32'h8000_0000,  32'd2,          32'h4000_0000,  32'd0};
    tbl[8] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
    tbl[9] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9};

    #12;
    chk("reset_ready_valid", {30'd0, in_ready, out_valid}, 32'd2);
    chk("reset_q", quotient, 0);
    chk("reset_r", remainder, 0);
    resetn = 1'b1;
    tick;

    foreach (tbl[i]) run_op(tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, $sformatf("vec%0d", i));

    // Result held under back-pressure while in_valid stays high with new operands.
    in_valid = 1'b1; div_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    tick;
    dividend = 32'd5; divisor = 32'd1;
    wait_result("hold");
    for (int i = 0; i < 10; i++) begin
      chk("hold_q", quotient, 32'd333);
      chk("hold_r", remainder, 32'd1);
      chk("hold_flags", {30'd0, in_ready, out_valid}, 32'd1);
      dividend = $urandom;
      tick;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("hold_release", {30'd0, in_ready, out_valid}, 32'd2);
    run_op(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, "after_hold");

    // Cancel beats accept in IDLE.
    in_valid = 1'b1; cancel = 1'b1; dividend = 32'd9; divisor = 32'd3;
    tick;
    in_valid = 1'b0; cancel = 1'b0;
    chk("cancel_vs_accept", {30'd0, in_ready, out_valid}, 32'd2);

    // Cancel during step 15: no result ever appears.
    begin
      int seen = 0;
      in_valid = 1'b1; dividend = 32'd77; divisor = 32'd5;
      tick;
      in_valid = 1'b0;
      repeat (14) tick;
      cancel = 1'b1;
      tick;
      cancel = 1'b0;
      chk("cancel_idle", {30'd0, in_ready, out_valid}, 32'd2);
      repeat (40) begin
        if (out_valid) seen++;
        tick;
      end
      chk("cancel_no_result", seen, 0);
    end

    // Asynchronous reset mid-CALC.
    in_valid = 1'b1; div_signed = 1'b0; dividend = 32'd123; divisor = 32'd4;
    tick;
    in_valid = 1'b0;
    repeat (10) tick;
    #2 resetn = 1'b0;
    #1;
    chk("areset_flags", {30'd0, in_ready, out_valid}, 32'd2);
    chk("areset_q", quotient, 0);
    chk("areset_r", remainder, 0);
    tick;
    resetn = 1'b1;
    tick;
    run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "after_reset");

    for (int k = 0; k < 150; k++) begin
      logic        s;
      logic [31:0] a, b, eq, er;
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom_range(0, 20);
        1: b = -$urandom_range(1, 20);
        2: b = a;
        default: b = $urandom;
      endcase
      if (k % 25 == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      model(s, a, b, eq, er);
      run_op(s, a, b, eq, er, $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
